// File: rtl/aes_axis_tx_pkg.sv
// Shared widths and state encoding for the AES output-side AXI4-Stream streamer.
package aes_axis_tx_pkg;

    localparam int unsigned BLK_S     = 128;
    localparam int unsigned AXIS_W    = 32;
    localparam int unsigned BLK_BEATS = BLK_S / AXIS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/aes_axis_tx_blk_serializer.sv
// Holds one AES block and presents it as AXIS_WIDTH-wide words, most significant word first.
module aes_axis_tx_blk_serializer #(
    parameter int unsigned BLK_WIDTH  = 128,
    parameter int unsigned AXIS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [BLK_WIDTH-1:0]  load_data,
    input  logic                  advance,
    output logic [AXIS_WIDTH-1:0] word,
    output logic                  last_beat
);

    localparam int unsigned BEATS  = BLK_WIDTH / AXIS_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BLK_WIDTH-1:0] hold;
    logic [BEAT_W-1:0]    beat;

    // Holding register and beat index: a load restarts at beat 0, advance steps to the next word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold <= '0;
            beat <= '0;
        end else if (load) begin
            hold <= load_data;
            beat <= '0;
        end else if (advance) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    // Word select: beat 0 maps to the top AXIS_WIDTH bits of the block.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat == BEAT_W'(i)) begin
                word = hold[BLK_WIDTH-1-i*AXIS_WIDTH -: AXIS_WIDTH];
            end
        end
    end

    assign last_beat = (beat == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/aes_axis_tx.sv
// AES output streamer: pops 128-bit result blocks from the output FIFO and emits them
// as 32-bit M_AXIS beats, with TLAST on the final beat of the command's last block.
module aes_axis_tx
    import aes_axis_tx_pkg::*;
#(
    parameter int unsigned BLK_WIDTH   = BLK_S,
    parameter int unsigned AXIS_WIDTH  = AXIS_W,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  blk_count,
    input  logic                    out_fifo_read_tvalid,
    output logic                    out_fifo_read_tready,
    input  logic [BLK_WIDTH-1:0]    out_fifo_data,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done
);

    tx_state_t              state, state_nx;
    logic [COUNT_WIDTH-1:0] remaining, remaining_nx;
    logic                   done_nx;
    logic                   ser_load, ser_advance, ser_last;
    logic [AXIS_WIDTH-1:0]  ser_word;
    logic                   m_hs;
    logic                   last_blk;

    aes_axis_tx_blk_serializer #(
        .BLK_WIDTH  (BLK_WIDTH),
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .load      (ser_load),
        .load_data (out_fifo_data),
        .advance   (ser_advance),
        .word      (ser_word),
        .last_beat (ser_last)
    );

    // tvalid comes straight from the state register, so it never depends on tready.
    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = m_axis_tvalid ? ser_word : '0;
    assign m_axis_tstrb  = m_axis_tvalid ? '1 : '0;
    assign last_blk      = (remaining == COUNT_WIDTH'(1));
    assign m_axis_tlast  = m_axis_tvalid && ser_last && last_blk;
    assign busy          = (state != IDLE);
    assign m_hs          = m_axis_tvalid && m_axis_tready;

    // State, block counter and done pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            done      <= done_nx;
        end
    end

    // Next-state and FIFO handshake. On the last beat of a non-final block the next word is
    // popped in the same cycle so consecutive blocks stream without a bubble.
    always_comb begin
        state_nx             = state;
        remaining_nx         = remaining;
        done_nx              = 1'b0;
        out_fifo_read_tready = 1'b0;
        ser_load             = 1'b0;
        ser_advance          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (blk_count != '0) begin
                        remaining_nx = blk_count;
                        state_nx     = FETCH;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            FETCH: begin
                out_fifo_read_tready = 1'b1;
                if (out_fifo_read_tvalid) begin
                    ser_load = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (m_hs) begin
                    if (!ser_last) begin
                        ser_advance = 1'b1;
                    end else if (last_blk) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        out_fifo_read_tready = 1'b1;
                        remaining_nx         = remaining - COUNT_WIDTH'(1);
                        if (out_fifo_read_tvalid) begin
                            ser_load = 1'b1;
                        end else begin
                            state_nx = FETCH;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_axis_tx.sv
// Directed bench for aes_axis_tx: FIFO modelled as a queue, beats captured on the falling edge.
module tb_aes_axis_tx;

    localparam int unsigned BLK = 128;
    localparam int unsigned AW  = 32;
    localparam int unsigned CW  = 16;

    localparam logic [127:0] B0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B1 = 128'h10000001_10000002_10000003_10000004;
    localparam logic [127:0] B2 = 128'h20000001_20000002_20000003_20000004;
    localparam logic [127:0] B3 = 128'h30000001_30000002_30000003_30000004;
    localparam logic [127:0] B4 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] B5 = 128'h50000001_50000002_50000003_50000004;
    localparam logic [127:0] B6 = 128'h60000001_60000002_60000003_60000004;
    localparam logic [127:0] B7 = 128'h70000001_70000002_70000003_70000004;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [CW-1:0]   blk_count;
    logic            out_fifo_read_tvalid;
    logic            out_fifo_read_tready;
    logic [BLK-1:0]  out_fifo_data;
    logic [AW-1:0]   m_axis_tdata;
    logic [AW/8-1:0] m_axis_tstrb;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    aes_axis_tx #(
        .BLK_WIDTH   (BLK),
        .AXIS_WIDTH  (AW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .start                (start),
        .blk_count            (blk_count),
        .out_fifo_read_tvalid (out_fifo_read_tvalid),
        .out_fifo_read_tready (out_fifo_read_tready),
        .out_fifo_data        (out_fifo_data),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tstrb         (m_axis_tstrb),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tlast         (m_axis_tlast),
        .busy                 (busy),
        .done                 (done)
    );

    int           checks = 0;
    int           failures = 0;
    logic [127:0] fifo_q[$];
    logic [31:0]  exp_q[$];
    logic [32:0]  beat_q[$];
    int           beat_cyc[$];
    int           cyc = 0;
    int           c0 = 0;
    int           pops, done_cnt, done_cyc, valid_cycles, hold_err, stall_cnt, strb_err;
    logic         prev_stall;
    logic [31:0]  prev_data;
    logic         prev_last;
    logic [5:0]   rdy_pat;
    int unsigned  rdy_idx;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_drive();
        out_fifo_read_tvalid = (fifo_q.size() != 0);
        out_fifo_data        = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic expect_block(input logic [127:0] b);
        exp_q.push_back(b[127:96]);
        exp_q.push_back(b[95:64]);
        exp_q.push_back(b[63:32]);
        exp_q.push_back(b[31:0]);
    endtask

    task automatic set_ready(input logic [5:0] pat);
        rdy_pat       = pat;
        rdy_idx       = 0;
        m_axis_tready = pat[0];
    endtask

    task automatic clear_log();
        beat_q.delete();
        beat_cyc.delete();
        exp_q.delete();
        pops = 0; done_cnt = 0; done_cyc = -1; valid_cycles = 0;
        hold_err = 0; stall_cnt = 0; strb_err = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    endtask

    // One clock: observe on the falling edge, then apply the FIFO pop and next ready value after the rising edge.
    task automatic step();
        logic do_pop;
        do_pop = 1'b0;
        @(negedge clk);
        cyc++;
        if (m_axis_tvalid) begin
            valid_cycles++;
            if (m_axis_tstrb != 4'hF) strb_err++;
            if (prev_stall && (m_axis_tdata != prev_data || m_axis_tlast != prev_last)) hold_err++;
        end else if (prev_stall) begin
            hold_err++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        if (prev_stall) stall_cnt++;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back({m_axis_tlast, m_axis_tdata});
            beat_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_fifo_read_tvalid && out_fifo_read_tready) begin
            pops++;
            do_pop = 1'b1;
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(fifo_q.pop_front());
        rdy_idx       = (rdy_idx + 1) % 6;
        m_axis_tready = rdy_pat[rdy_idx];
        fifo_drive();
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start     = 1'b1;
        blk_count = n;
        step();
        start     = 1'b0;
        c0        = cyc;
    endtask

    task automatic run_until_done(input int budget);
        for (int n = 0; n < budget && done_cnt == 0; n++) step();
    endtask

    task automatic run_until_beats(input int nb, input int budget);
        for (int n = 0; n < budget && beat_q.size() < nb; n++) step();
    endtask

    task automatic verify_beats(input string tag);
        logic [32:0] got;
        check($sformatf("%s_nbeats", tag), beat_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            got = (i < beat_q.size()) ? beat_q[i] : '0;
            check($sformatf("%s_d%0d", tag, i), got[31:0], exp_q[i]);
            check($sformatf("%s_l%0d", tag, i), got[32], (i == exp_q.size() - 1));
        end
        check($sformatf("%s_strb", tag), strb_err, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        blk_count = '0;
        set_ready(6'b111111);
        fifo_drive();
        clear_log();

        // Reset state
        #12;
        check("rst_ctl", {m_axis_tvalid, m_axis_tlast, busy, done, out_fifo_read_tready}, 5'b0);
        check("rst_data", {m_axis_tdata, m_axis_tstrb}, '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step();
        step();
        check("idle_ctl", {m_axis_tvalid, busy, done, out_fifo_read_tready}, 4'b0);

        // 1: single block, latency and done timing
        clear_log();
        fifo_q.push_back(B0);
        fifo_drive();
        expect_block(B0);
        do_start(1);
        check("t1_busy", busy, 1'b1);
        run_until_done(30);
        step();
        verify_beats("t1");
        check("t1_first_cyc", (beat_cyc.size() > 0) ? beat_cyc[0] : -1, c0 + 2);
        check("t1_last_cyc", (beat_cyc.size() > 3) ? beat_cyc[3] : -1, c0 + 5);
        check("t1_done_cyc", done_cyc, c0 + 6);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_pops", pops, 1);
        check("t1_busy_after", {busy, done}, 2'b00);

        // 2: three preloaded blocks stream back to back
        clear_log();
        fifo_q.push_back(B1); fifo_q.push_back(B2); fifo_q.push_back(B3);
        fifo_drive();
        expect_block(B1); expect_block(B2); expect_block(B3);
        do_start(3);
        run_until_done(40);
        verify_beats("t2");
        check("t2_contig", (beat_cyc.size() == 12) ? beat_cyc[11] - beat_cyc[0] : -1, 11);
        check("t2_pops", pops, 3);
        check("t2_done_cnt", done_cnt, 1);

        // 3: backpressure 1,0,0,1,0,1 repeating
        clear_log();
        fifo_q.push_back(B1); fifo_q.push_back(B4);
        fifo_drive();
        expect_block(B1); expect_block(B4);
        set_ready(6'b101001);
        do_start(2);
        run_until_done(80);
        verify_beats("t3");
        check("t3_hold", hold_err, 0);
        check("t3_stalled", stall_cnt > 0, 1'b1);
        check("t3_pops", pops, 2);
        set_ready(6'b111111);
        step();

        // 4: FIFO underrun between blocks
        clear_log();
        fifo_q.push_back(B2);
        fifo_drive();
        expect_block(B2); expect_block(B3);
        do_start(2);
        run_until_beats(4, 30);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("t4_gap%0d", g), {m_axis_tvalid, out_fifo_read_tready, busy}, 3'b011);
            step();
        end
        fifo_q.push_back(B3);
        fifo_drive();
        run_until_done(30);
        verify_beats("t4");
        check("t4_pops", pops, 2);
        check("t4_hold", hold_err, 0);

        // 5: zero-length command, then start while busy
        clear_log();
        fifo_q.push_back(B4);
        fifo_drive();
        do_start(0);
        check("t5_done_pulse", {done, busy, m_axis_tvalid}, 3'b100);
        step();
        check("t5_done_clear", done, 1'b0);
        step();
        check("t5_no_pop", pops, 0);
        check("t5_no_valid", valid_cycles, 0);
        clear_log();
        expect_block(B4);
        set_ready(6'b000000);
        do_start(1);
        for (int k = 0; k < 3; k++) step();
        start     = 1'b1;
        blk_count = 5;
        step();
        start     = 1'b0;
        check("t5_busy_hold", {busy, m_axis_tvalid}, 2'b11);
        set_ready(6'b111111);
        run_until_done(40);
        verify_beats("t5");
        check("t5_pops", pops, 1);
        check("t5_hold", hold_err, 0);

        // 6: asynchronous reset mid-command, then a fresh command
        clear_log();
        fifo_q.push_back(B5); fifo_q.push_back(B6); fifo_q.push_back(B7);
        fifo_drive();
        do_start(2);
        run_until_beats(2, 30);
        resetn = 1'b0;
        #1;
        check("t6_rst_ctl", {m_axis_tvalid, m_axis_tlast, busy, done, out_fifo_read_tready}, 5'b0);
        check("t6_rst_data", {m_axis_tdata, m_axis_tstrb}, '0);
        #2 resetn = 1'b1;
        clear_log();
        step();
        step();
        check("t6_idle", {busy, m_axis_tvalid}, 2'b00);
        check("t6_fifo_left", fifo_q.size(), 2);
        expect_block(B6);
        do_start(1);
        run_until_done(30);
        verify_beats("t6");
        check("t6_pops", pops, 1);
        check("t6_fifo_rem", fifo_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
